univ_shift_reg: RTL and testbench

Parametrised universal register: the next generation of the team's single-bit D flip-flop, which only loads D and has a synchronous reset. It adds WIDTH-bit storage, clock enable, load/shift/rotate/clear modes and serial I/O. It also adds a multi-cycle burst engine that applies one shift or rotate Count times with a Busy/Done handshake. It sits in datapaths as a general-purpose state register, serializer or barrel-shift substitute.

---
 rtl/univ_shift_reg.sv | 154 +++++++++++++++
 tb/tb_univ_shift_reg.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/univ_shift_reg.sv
// Universal WIDTH-bit register: hold/load/shift/rotate/clear with serial I/O,
// plus a burst engine that repeats one shift or rotate Count times.
module univ_shift_reg #(
    parameter int unsigned          WIDTH   = 8,
    parameter logic [WIDTH-1:0]     RST_VAL = '0,
    localparam int unsigned         CW      = $clog2(WIDTH + 1)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             en_i,
    input  logic [2:0]       mode_i,
    input  logic [WIDTH-1:0] d_i,
    input  logic             sin_i,
    input  logic             start_i,
    input  logic [CW-1:0]    count_i,
    output logic [WIDTH-1:0] q_o,
    output logic [WIDTH-1:0] q_bar_o,
    output logic             sout_o,
    output logic             busy_o,
    output logic             done_o
);

    localparam logic [2:0] ModeHold  = 3'b000;
    localparam logic [2:0] ModeLoad  = 3'b001;
    localparam logic [2:0] ModeShl   = 3'b010;
    localparam logic [2:0] ModeLshr  = 3'b011;
    localparam logic [2:0] ModeAshr  = 3'b100;
    localparam logic [2:0] ModeRol   = 3'b101;
    localparam logic [2:0] ModeRor   = 3'b110;
    localparam logic [2:0] ModeClear = 3'b111;

    typedef enum logic [0:0] {StIdle, StRun} state_e;

    state_e           state_q, state_d;
    logic [2:0]       mode_q, mode_d;
    logic [CW-1:0]    rem_q, rem_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic             sout_q, sout_d;
    logic             done_q, done_d;

    logic [2:0]       step_mode;
    logic [WIDTH-1:0] step_q;
    logic             step_sout;
    logic             burst_mode;

    // In RUN the latched mode drives the step; in IDLE the live mode does.
    assign step_mode  = (state_q == StRun) ? mode_q : mode_i;
    // Only shifts and rotates may span more than one step.
    assign burst_mode = (mode_i >= ModeShl) && (mode_i <= ModeRor);

    // Result of applying one step of step_mode to the current contents.
    always_comb begin
        step_q    = q_q;
        step_sout = sout_q;
        unique case (step_mode)
            ModeHold:  step_q = q_q;
            ModeLoad:  step_q = d_i;
            ModeShl: begin
                step_q    = {q_q[WIDTH-2:0], sin_i};
                step_sout = q_q[WIDTH-1];
            end
            ModeLshr: begin
                step_q    = {sin_i, q_q[WIDTH-1:1]};
                step_sout = q_q[0];
            end
            ModeAshr: begin
                step_q    = {q_q[WIDTH-1], q_q[WIDTH-1:1]};
                step_sout = q_q[0];
            end
            ModeRol: begin
                step_q    = {q_q[WIDTH-2:0], q_q[WIDTH-1]};
                step_sout = q_q[WIDTH-1];
            end
            ModeRor: begin
                step_q    = {q_q[0], q_q[WIDTH-1:1]};
                step_sout = q_q[0];
            end
            ModeClear: step_q = RST_VAL;
            default:   step_q = q_q;
        endcase
    end

    // Next-state: request acceptance in IDLE, step countdown in RUN.
    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        rem_d   = rem_q;
        q_d     = q_q;
        sout_d  = sout_q;
        done_d  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start_i) begin
                    if (count_i == '0) begin
                        // Zero-length request completes without touching Q.
                        done_d = 1'b1;
                    end else begin
                        q_d    = step_q;
                        sout_d = step_sout;
                        if (burst_mode && (count_i > CW'(1))) begin
                            state_d = StRun;
                            mode_d  = mode_i;
                            rem_d   = count_i - CW'(1);
                        end else begin
                            done_d = 1'b1;
                        end
                    end
                end else if (en_i) begin
                    q_d    = step_q;
                    sout_d = step_sout;
                end
            end
            StRun: begin
                q_d    = step_q;
                sout_d = step_sout;
                rem_d  = rem_q - CW'(1);
                if (rem_q == CW'(1)) begin
                    state_d = StIdle;
                    done_d  = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State registers; reset aborts any burst in flight.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= StIdle;
            mode_q  <= ModeHold;
            rem_q   <= '0;
            q_q     <= RST_VAL;
            sout_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            rem_q   <= rem_d;
            q_q     <= q_d;
            sout_q  <= sout_d;
            done_q  <= done_d;
        end
    end

    // Outputs are direct register views; Q_bar is purely combinational.
    always_comb begin
        q_o     = q_q;
        q_bar_o = ~q_q;
        sout_o  = sout_q;
        busy_o  = (state_q == StRun);
        done_o  = done_q;
    end

endmodule

// File: tb/tb_univ_shift_reg.sv
// Directed bench for univ_shift_reg (WIDTH=8, RST_VAL=0).
module tb_univ_shift_reg;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic [2:0] mode;
    logic [7:0] d;
    logic       sin;
    logic       start;
    logic [3:0] count;
    logic [7:0] q;
    logic [7:0] q_bar;
    logic       sout;
    logic       busy;
    logic       done;

    int n_checks = 0;
    int n_fail   = 0;

    univ_shift_reg #(
        .WIDTH   (8),
        .RST_VAL (8'h00)
    ) dut (
        .clk_i   (clk),
        .rst_ni  (rst_n),
        .en_i    (en),
        .mode_i  (mode),
        .d_i     (d),
        .sin_i   (sin),
        .start_i (start),
        .count_i (count),
        .q_o     (q),
        .q_bar_o (q_bar),
        .sout_o  (sout),
        .busy_o  (busy),
        .done_o  (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Advance one active edge and settle just after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [7:0] val);
        start = 1'b0;
        en    = 1'b1;
        mode  = 3'b001;
        d     = val;
        tick();
        en    = 1'b0;
    endtask

    initial begin
        int  n;
        logic saw_done;

        rst_n = 1'b0;
        en    = 1'b0;
        mode  = 3'b000;
        d     = 8'h00;
        sin   = 1'b0;
        start = 1'b0;
        count = 4'd0;
        repeat (2) tick();
        check("rst_q", q, 8'h00);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;

        // Load then shift left
        en = 1'b1; mode = 3'b001; d = 8'hA5;
        tick();
        check("load_q", q, 8'hA5);
        check("load_qbar", q_bar, 8'h5A);
        mode = 3'b010; sin = 1'b1;
        tick();
        check("shl_q", q, 8'h4B);
        check("shl_sout", sout, 1'b1);

        // Asynchronous reset between edges
        en = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_q", q, 8'h00);
        check("arst_qbar", q_bar, 8'hFF);
        check("arst_sout", sout, 1'b0);
        check("arst_busy", busy, 1'b0);
        check("arst_done", done, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        check("post_rst_q", q, 8'h00);

        // Arithmetic then logical shift right
        load(8'h96);
        en = 1'b1; mode = 3'b100;
        tick();
        check("asr_q", q, 8'hCB);
        check("asr_sout", sout, 1'b0);
        load(8'h96);
        en = 1'b1; mode = 3'b011; sin = 1'b0;
        tick();
        check("lsr_q", q, 8'h4B);

        // Rotate-left burst of 3, with an ignored Start while busy
        load(8'h81);
        start = 1'b1; mode = 3'b101; count = 4'd3;
        tick();
        check("rol1_q", q, 8'h03);
        check("rol1_busy", busy, 1'b1);
        check("rol1_done", done, 1'b0);
        check("rol1_sout", sout, 1'b1);
        start = 1'b1; mode = 3'b001; d = 8'hFF;
        tick();
        check("rol2_q", q, 8'h06);
        check("rol2_busy", busy, 1'b1);
        check("rol2_done", done, 1'b0);
        start = 1'b0;
        tick();
        check("rol3_q", q, 8'h0C);
        check("rol3_busy", busy, 1'b0);
        check("rol3_done", done, 1'b1);
        check("rol3_sout", sout, 1'b0);
        tick();
        check("rol_after_done", done, 1'b0);
        check("rol_after_q", q, 8'h0C);

        // Count=0: Done pulse only
        load(8'h3C);
        start = 1'b1; mode = 3'b101; count = 4'd0;
        tick();
        start = 1'b0;
        check("cnt0_q", q, 8'h3C);
        check("cnt0_done", done, 1'b1);
        check("cnt0_busy", busy, 1'b0);
        tick();
        check("cnt0_done_clr", done, 1'b0);

        // Count=10 rotate right, wraps modulo 8
        load(8'h01);
        start = 1'b1; mode = 3'b110; count = 4'd10;
        tick();
        start = 1'b0;
        n = 0;
        while (busy && n < 20) begin
            n++;
            tick();
        end
        check("cnt10_busy_cycles", n, 9);
        check("cnt10_q", q, 8'h40);
        check("cnt10_done", done, 1'b1);

        // Reset during a burst of 6
        load(8'h01);
        start = 1'b1; mode = 3'b101; count = 4'd6;
        tick();
        start = 1'b0;
        tick();
        tick();
        check("rb_pre_q", q, 8'h08);
        #2;
        rst_n = 1'b0;
        #1;
        check("rb_q", q, 8'h00);
        check("rb_busy", busy, 1'b0);
        check("rb_done", done, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        saw_done = 1'b0;
        repeat (4) begin
            tick();
            saw_done = saw_done | done | busy;
        end
        check("rb_no_done", saw_done, 1'b0);

        // Normal burst of 2 after the aborted one
        load(8'hC0);
        start = 1'b1; mode = 3'b101; count = 4'd2;
        tick();
        start = 1'b0;
        check("b2_q1", q, 8'h81);
        check("b2_busy1", busy, 1'b1);
        check("b2_done1", done, 1'b0);
        tick();
        check("b2_q2", q, 8'h03);
        check("b2_busy2", busy, 1'b0);
        check("b2_done2", done, 1'b1);
        check("b2_sout", sout, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
